t05_stage_controller: RTL

//  Top-level sequencer for the team_05 Huffman encoder pipeline. Drives the shared
//  en_state bus through histogram(1), freq-list(2), tree(3), codebook(4), translation(5);

---
 rtl/t05_stage_controller.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/t05_stage_controller.sv
// Stage sequencer for the team_05 Huffman encoder: steps en_state through stages 1..5, grants the SRAM port to the active stage.
// Optional per-stage watchdog built when T05_WATCHDOG_EN is defined.
//
// state | meaning
// ------+--------------------------------------------
// IDLE  | 0: waiting for start
// S_HIST| 1: histogram stage active
// S_FREQ| 2: frequency-list stage active
// S_TREE| 3: tree-build stage active
// S_CODE| 4: codebook stage active
// S_XLAT| 5: translation stage active
// DONE  | 6: encode complete, waiting for start/abort
// ERROR | 7: bad finish code or watchdog timeout, waiting for abort
module t05_stage_controller #(
  parameter int                 WDT_W     = 24,
  parameter logic [WDT_W-1:0]   WDT_LIMIT = 24'hFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] fin_state,
  input  logic [4:0] sram_req,
  output logic [3:0] en_state,
  output logic [4:0] sram_gnt,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_stage,
  output logic       err_wdt
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_HIST = 4'd1,
    S_FREQ = 4'd2,
    S_TREE = 4'd3,
    S_CODE = 4'd4,
    S_XLAT = 4'd5,
    DONE   = 4'd6,
    ERROR  = 4'd7
  } state_t;

  state_t     state, state_n;
  logic [4:0] gnt_n;
  logic [3:0] err_stage_n;
  logic       err_wdt_n;
  logic       wdt_hit;
  logic [3:0] fin_ok_code;
  logic [4:0] stage_bit;

  assign fin_ok_code = state + 4'd1;
  assign stage_bit   = 5'b00001 << (state - 4'd1);

`ifdef T05_WATCHDOG_EN
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_LIMIT - WDT_W'(1);
  logic [WDT_W-1:0] wdt_cnt;

  assign wdt_hit = (wdt_cnt == WDT_LAST);

  // Restarts on any state change, so each stage gets the full budget.
  always_ff @(posedge clk) begin
    if (rst)
      wdt_cnt <= '0;
    else if (state_n != state)
      wdt_cnt <= '0;
    else if (busy && (wdt_cnt != '1))
      wdt_cnt <= wdt_cnt + WDT_W'(1);
  end
`else
  logic unused_wdt;
  assign unused_wdt = ^WDT_LIMIT;
  assign wdt_hit    = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    gnt_n       = '0;
    err_stage_n = err_stage;
    err_wdt_n   = err_wdt;
    case (state)
      IDLE: begin
        if (!abort && start) state_n = S_HIST;
      end
      S_HIST, S_FREQ, S_TREE, S_CODE, S_XLAT: begin
        if (abort) begin
          state_n     = IDLE;
          err_stage_n = 4'd0;
          err_wdt_n   = 1'b0;
        end else if (fin_state == fin_ok_code) begin
          state_n = state_t'(fin_ok_code);
        end else if (fin_state != 4'd0) begin
          state_n     = ERROR;
          err_stage_n = state;
          err_wdt_n   = 1'b0;
        end else if (wdt_hit) begin
          state_n     = ERROR;
          err_stage_n = state;
          err_wdt_n   = 1'b1;
        end else begin
          gnt_n = sram_req & stage_bit;
        end
      end
      DONE: begin
        if (abort)      state_n = IDLE;
        else if (start) state_n = S_HIST;
      end
      ERROR: begin
        if (abort) begin
          state_n     = IDLE;
          err_stage_n = 4'd0;
          err_wdt_n   = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        err_stage_n = 4'd0;
        err_wdt_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sram_gnt  <= '0;
      err_stage <= 4'd0;
      err_wdt   <= 1'b0;
    end else begin
      state     <= state_n;
      sram_gnt  <= gnt_n;
      err_stage <= err_stage_n;
      err_wdt   <= err_wdt_n;
    end
  end

  assign en_state = state;
  assign busy     = (state >= S_HIST) && (state <= S_XLAT);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

endmodule
